// File: rtl/seq_serializer.sv
// Serial pattern transmitter: captures a parallel pattern and length, then shifts it out MSB-first.
// Optional macro SEQ_SERIALIZER_PARITY_EN appends an even-parity bit after the pattern.
module seq_serializer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [CNT_W-1:0] len,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd3;
`endif
    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    logic [1:0]       state_r, state_s;
    logic [WIDTH-1:0] sreg_r, sreg_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] len_c_s;
    logic [WIDTH-1:0] aligned_s;
    logic             out_r, out_s;
    logic             valid_r, valid_s;
    logic             done_r, done_s;
    logic             busy_r;
`ifdef SEQ_SERIALIZER_PARITY_EN
    logic             par_r, par_s;

    // Bits above the used field are shifted out of the aligned word, so a plain XOR suffices.
    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction
`endif

    // Clamp the requested length and left-align the used field so the MSB sits at the top.
    always_comb begin
        if (len > WIDTH_C) begin
            len_c_s = WIDTH_C;
        end else begin
            len_c_s = len;
        end
        aligned_s = data << (WIDTH_C - len_c_s);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = (len_c_s == {CNT_W{1'b0}}) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
                    state_s = ST_PAR;
`else
                    state_s = ST_DONE;
`endif
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
`ifdef SEQ_SERIALIZER_PARITY_EN
            ST_PAR:  state_s = ST_DONE;
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the datapath and the registered outputs.
    always_comb begin
        sreg_s  = sreg_r;
        cnt_s   = cnt_r;
        out_s   = 1'b0;
        valid_s = 1'b0;
        done_s  = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
        par_s   = par_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    sreg_s = aligned_s;
`ifdef SEQ_SERIALIZER_PARITY_EN
                    par_s  = even_parity(aligned_s);
`endif
                    if (len_c_s == {CNT_W{1'b0}}) begin
                        cnt_s  = {CNT_W{1'b0}};
                        done_s = 1'b1;
                    end else begin
                        cnt_s   = len_c_s - CNT_W'(1);
                        out_s   = aligned_s[WIDTH-1];
                        valid_s = 1'b1;
                    end
                end else begin
                    sreg_s = sreg_r;
                end
            end
            ST_SHIFT: begin
                // The counter holds the index of the bit on the line; it stops at zero.
                if (cnt_r != {CNT_W{1'b0}}) begin
                    sreg_s  = sreg_r << 1;
                    cnt_s   = cnt_r - CNT_W'(1);
                    out_s   = sreg_r[WIDTH-2];
                    valid_s = 1'b1;
                end else begin
`ifdef SEQ_SERIALIZER_PARITY_EN
                    out_s   = par_r;
                    valid_s = 1'b1;
`else
                    done_s  = 1'b1;
`endif
                end
            end
`ifdef SEQ_SERIALIZER_PARITY_EN
            ST_PAR:  done_s = 1'b1;
`endif
            ST_DONE: done_s = 1'b0;
            default: done_s = 1'b0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            out_r   <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            sreg_r  <= sreg_s;
            cnt_r   <= cnt_s;
            out_r   <= out_s;
            valid_r <= valid_s;
            done_r  <= done_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

`ifdef SEQ_SERIALIZER_PARITY_EN
    // Captured parity of the pattern being sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_r <= 1'b0;
        end else begin
            par_r <= par_s;
        end
    end
`endif

    assign out   = out_r;
    assign valid = valid_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign state = state_r;

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: a reference model queues expected bits, a monitor checks them.
module tb_seq_serializer;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;
`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int DONE_TOKEN = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic [CNT_W-1:0] len = '0;
    logic             out, valid, busy, done;
    logic [1:0]       state;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    seq_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data), .len(len),
        .out(out), .valid(valid), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int l);
        return (l > WIDTH) ? WIDTH : l;
    endfunction

    // Reference: the used field MSB-first, optional even parity, then a done marker.
    function automatic void model_push(input logic [WIDTH-1:0] d, input int l);
        int n = clamp(l);
        int p = 0;
        for (int i = n - 1; i >= 0; i--) begin
            exp_q.push_back(int'(d[i]));
            p = p ^ int'(d[i]);
        end
        if (PAR_EN && n > 0) exp_q.push_back(p);
        exp_q.push_back(DONE_TOKEN);
    endfunction

    function automatic int busy_len(input int l);
        int n = clamp(l);
        if (n == 0) return 1;
        return n + 1 + (PAR_EN ? 1 : 0);
    endfunction

    // Monitor: pops one expectation for each valid bit or done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && done) check("valid_done_overlap", 1, 0);
            if (!valid && out) check("out_zero_when_idle", int'(out), 0);
            if (valid || done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", done ? DONE_TOKEN : int'(out), -1);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check(done ? "done_pulse" : "stream_bit", done ? DONE_TOKEN : int'(out), e);
                end
            end
        end
    end

    task automatic run_xfer(input logic [WIDTH-1:0] d, input int l, input bit disturb);
        int cycles = 0;
        int n = clamp(l);
        @(negedge clk);
        data  = d;
        len   = CNT_W'(l);
        start = 1'b1;
        model_push(d, l);
        @(negedge clk);
        start = 1'b0;
        check("first_state", int'(state), (n == 0) ? 2 : 1);
        while (busy && cycles < 100) begin
            cycles++;
            if (disturb) begin
                data  = WIDTH'($urandom);
                len   = CNT_W'($urandom_range(0, 31));
                start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", cycles, busy_len(l));
        check("queue_drained", exp_q.size(), 0);
        check("back_to_idle", int'(state), 0);
        @(negedge clk);
        check("no_retrigger", int'(busy), 0);
    endtask

    initial begin
        int cycles;
        int dn;
        int b;

        #12;
        check("reset_out", int'(out), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_state", int'(state), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_xfer(16'h6D95, 16, 1'b0);
        run_xfer(16'h0005, 3, 1'b0);
        run_xfer(16'h8001, 20, 1'b0);
        run_xfer(16'h0000, 0, 1'b0);
        run_xfer(16'hFFFF, 1, 1'b0);
        run_xfer(16'h0007, 3, 1'b0);
        run_xfer(16'h0003, 3, 1'b0);
        run_xfer(16'hA5C3, 16, 1'b1);

        // Reset mid-transfer: abort after five bits, no done afterwards.
        @(negedge clk);
        data = 16'hFFFF; len = 5'd16; start = 1'b1;
        model_push(16'hFFFF, 16);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out", int'(out), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_state", int'(state), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_xfer(16'h6D95, 16, 1'b0);

        // Start held high: three transfers separated by one idle cycle each.
        b = busy_len(5);
        @(negedge clk);
        data = 16'h0016; len = 5'd5; start = 1'b1;
        for (int k = 0; k < 3; k++) model_push(16'h0016, 5);
        cycles = 0;
        dn = 0;
        while (dn < 3 && cycles < 500) begin
            @(negedge clk);
            cycles++;
            if (done) dn++;
        end
        start = 1'b0;
        check("held_start_cycles", cycles, 3 * b + 2);
        repeat (3) @(negedge clk);
        check("held_start_stopped", int'(busy), 0);
        check("held_start_drained", exp_q.size(), 0);

        for (int i = 0; i < 30; i++) begin
            run_xfer(WIDTH'($urandom), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
